// File: rtl/hilbert_sequencer_pkg.sv
// Shared definitions for the Hilbert bank sequencer: FSM state encoding and
// the width helper used to size counters from their terminal values.
package hilbert_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_RUN,
    ST_DRAIN,
    ST_FAULT
  } seq_state_t;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int log2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hilbert_strobe_gen.sv
// Supersample divider and lock timer for the Hilbert bank sequencer.
// The divider drives the bank strobe once every RATIO clocks while the bank
// is enabled; the timer flags when the lock window has been used up.
module hilbert_strobe_gen
  import hilbert_sequencer_pkg::*;
#(
  parameter int RATIO     = 2,
  parameter int LOCK_WAIT = 16
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,   // next clock is the first clock of LOCK
  input  logic active_i,  // next clock is LOCK, RUN or DRAIN
  output logic stb_o,     // registered divider terminal-count strobe
  output logic tmo_o      // timer has reached LOCK_WAIT-1
);

  localparam int DW = log2w(RATIO);
  localparam int TW = log2w(LOCK_WAIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(RATIO - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(LOCK_WAIT - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [TW-1:0] tmr_q;

  // Next divider value: restart at 0 on LOCK entry or while the bank is off.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    div_d = '0;
    if (active_i && !clear_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // Divider register and strobe, registered from the next divider value.
  always_ff @(posedge clock_i or posedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      div_q <= '0;
      stb_o <= 1'b0;
    end else begin
      div_q <= div_d;
      stb_o <= active_i && (div_d == DIV_LAST);
    end
  end

  // Lock timer: cleared on LOCK entry, then counts and holds at its last value.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tmr_q <= '0;
    end else if (clear_i) begin
      tmr_q <= '0;
    end else if (tmr_q != TMR_LAST) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign tmo_o = (tmr_q == TMR_LAST);

endmodule

// File: rtl/hilbert_sequencer.sv
// Sequencer for a fake_hilbert bank: enables the bank, waits for lock,
// counts framed samples into blocks of BLOCK and stops at a block boundary.
// Lock timeout or lock loss parks the sequencer in a sticky FAULT state.
module hilbert_sequencer
  import hilbert_sequencer_pkg::*;
#(
  parameter int RATIO     = 2,
  parameter int LOCK_WAIT = 16,
  parameter int BLOCK     = 32
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      locked_i,
  input  logic                      hstrobe_i,
  input  logic                      framed_i,
  output logic                      hilb_en_o,
  output logic                      hilb_stb_o,
  output logic                      busy_o,
  output logic                      run_o,
  output logic                      block_o,
  output logic                      fault_o,
  output logic [log2w(BLOCK)-1:0]   count_o
);

  localparam int CW = log2w(BLOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK - 1);

  seq_state_t    state_q;
  seq_state_t    state_d;
  logic [CW-1:0] count_d;
  logic          block_d;
  logic          qual;
  logic          last;
  logic          lock_entry;
  logic          active_d;
  logic          tmo;

  assign qual       = hstrobe_i & framed_i;
  assign last       = (count_o == CNT_LAST);
  assign lock_entry = (state_d == ST_LOCK) && (state_q != ST_LOCK);
  assign active_d   = (state_d == ST_LOCK) || (state_d == ST_RUN) ||
                      (state_d == ST_DRAIN);

  hilbert_strobe_gen #(
    .RATIO     (RATIO),
    .LOCK_WAIT (LOCK_WAIT)
  ) u_strobe_gen (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (lock_entry),
    .active_i (active_d),
    .stb_o    (hilb_stb_o),
    .tmo_o    (tmo)
  );

  // Next state, next sample count and block-complete pulse.
  always_comb begin
    state_d = state_q;
    count_d = count_o;
    block_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (locked_i)  state_d = ST_RUN;
        else if (tmo)  state_d = ST_FAULT;
      end
      ST_RUN, ST_DRAIN: begin
        if (qual) count_d = last ? '0 : count_o + 1'b1;
        // Lock loss outranks both stop and block completion.
        if (!locked_i) begin
          state_d = ST_FAULT;
        end else begin
          block_d = qual && last;
          if (state_q == ST_RUN) begin
            // Stopping exactly on a boundary with nothing arriving skips DRAIN.
            if (stop_i) state_d = (count_o == '0 && !qual) ? ST_IDLE : ST_DRAIN;
          end else if (qual && last) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        if (start_i)     state_d = ST_LOCK;
        else if (stop_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (lock_entry) count_d = '0;
  end

  // State and all status outputs, registered from the next state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_o   <= '0;
      block_o   <= 1'b0;
      hilb_en_o <= 1'b0;
      busy_o    <= 1'b0;
      run_o     <= 1'b0;
      fault_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_o   <= count_d;
      block_o   <= block_d;
      hilb_en_o <= active_d;
      busy_o    <= active_d;
      run_o     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      fault_o   <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_hilbert_sequencer.sv
// Self-checking bench for hilbert_sequencer: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_hilbert_sequencer;

  localparam int RATIO     = 2;
  localparam int LOCK_WAIT = 16;
  localparam int BLOCK     = 4;
  localparam int CW        = 2;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          stop_i;
  logic          locked_i;
  logic          hstrobe_i;
  logic          framed_i;
  logic          hilb_en_o;
  logic          hilb_stb_o;
  logic          busy_o;
  logic          run_o;
  logic          block_o;
  logic          fault_o;
  logic [CW-1:0] count_o;

  always #5 clock_i = ~clock_i;

  hilbert_sequencer #(
    .RATIO     (RATIO),
    .LOCK_WAIT (LOCK_WAIT),
    .BLOCK     (BLOCK)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .locked_i   (locked_i),
    .hstrobe_i  (hstrobe_i),
    .framed_i   (framed_i),
    .hilb_en_o  (hilb_en_o),
    .hilb_stb_o (hilb_stb_o),
    .busy_o     (busy_o),
    .run_o      (run_o),
    .block_o    (block_o),
    .fault_o    (fault_o),
    .count_o    (count_o)
  );

  // Behavioural model: phase = clocks since LOCK entry, lock_age = clocks
  // spent in LOCK, samples = framed samples modulo BLOCK.
  typedef enum {M_IDLE, M_LOCK, M_RUN, M_DRAIN, M_FAULT} mode_t;
  mode_t mode;
  int    phase;
  int    lock_age;
  int    samples;
  logic  e_block;

  int passed = 0;
  int total  = 0;

  function automatic logic e_act();
    return (mode == M_LOCK) || (mode == M_RUN) || (mode == M_DRAIN);
  endfunction

  function automatic logic e_stb();
    return e_act() && ((phase % RATIO) == RATIO - 1);
  endfunction

  task automatic model_reset();
    mode = M_IDLE; phase = 0; lock_age = 0; samples = 0; e_block = 1'b0;
  endtask

  task automatic enter_lock();
    mode = M_LOCK; phase = 0; lock_age = 0; samples = 0;
  endtask

  task automatic model_step();
    logic qual;
    logic wrap;
    int   old;
    qual    = hstrobe_i & framed_i;
    e_block = 1'b0;
    case (mode)
      M_IDLE: if (start_i) enter_lock();
      M_LOCK: begin
        phase++;
        if (locked_i) mode = M_RUN;
        else if (lock_age == LOCK_WAIT - 1) mode = M_FAULT;
        lock_age++;
      end
      M_RUN, M_DRAIN: begin
        old  = samples;
        wrap = qual && (samples == BLOCK - 1);
        if (qual) samples = (samples + 1) % BLOCK;
        phase++;
        if (!locked_i) mode = M_FAULT;
        else begin
          e_block = wrap;
          if (mode == M_RUN && stop_i) mode = (old == 0 && !qual) ? M_IDLE : M_DRAIN;
          else if (mode == M_DRAIN && wrap) mode = M_IDLE;
        end
      end
      M_FAULT: begin
        if (start_i) enter_lock();
        else if (stop_i) mode = M_IDLE;
      end
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"},    32'(hilb_en_o),  32'(e_act()));
    check({tag, ".stb"},   32'(hilb_stb_o), 32'(e_stb()));
    check({tag, ".busy"},  32'(busy_o),     32'(e_act()));
    check({tag, ".run"},   32'(run_o),      32'(mode == M_RUN || mode == M_DRAIN));
    check({tag, ".block"}, 32'(block_o),    32'(e_block));
    check({tag, ".fault"}, 32'(fault_o),    32'(mode == M_FAULT));
    check({tag, ".count"}, 32'(count_o),    32'(samples));
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge clock_i);
    if (reset_i) model_reset();
    else model_step();
    @(negedge clock_i);
    check_all(tag);
  endtask

  // Clock with the bank's strobe fed back one clock late.
  task automatic tick_fb(input string tag);
    tick(tag);
    hstrobe_i = e_stb();
  endtask

  initial begin
    int b0, b1, t, n, blocks;
    bit reached;

    // Reset state
    reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; locked_i = 1'b0;
    hstrobe_i = 1'b0; framed_i = 1'b0;
    model_reset();
    tick("reset");
    tick("reset");
    reset_i = 1'b0;

    // Nominal run: lock 3 clocks after start, block_o every 8 clocks
    framed_i = 1'b1;
    start_i  = 1'b1;
    tick_fb("nom");
    start_i = 1'b0;
    tick_fb("nom");
    tick_fb("nom");
    locked_i = 1'b1;
    b0 = -1; b1 = -1;
    for (t = 0; t < 60 && b1 < 0; t++) begin
      tick_fb("nom");
      if (block_o) begin
        if (b0 < 0) b0 = t;
        else b1 = t;
      end
    end
    check("nom.block_spacing", 32'(b1 - b0), 32'd8);

    // Stop requested at count_o = 2: drain the block, one block_o, then idle
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick_fb("stop");
      reached = (samples == 2);
    end
    check("stop.reach_count2", 32'(reached), 32'd1);
    stop_i = 1'b1;
    tick_fb("stop");
    stop_i = 1'b0;
    check("stop.in_drain", 32'(run_o && mode == M_DRAIN), 32'd1);
    blocks = 0;
    for (int i = 0; i < 40 && mode != M_IDLE; i++) begin
      tick_fb("stop");
      if (block_o) blocks++;
    end
    check("stop.blocks", 32'(blocks), 32'd1);
    tick_fb("stop");
    check("stop.busy_after", 32'(busy_o), 32'd0);

    // Lock loss together with stop and the block's final framed strobe
    start_i = 1'b1;
    tick_fb("loss");
    start_i = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick_fb("loss");
      reached = (mode == M_RUN) && (samples == BLOCK - 1) && hstrobe_i;
    end
    check("loss.reach_last", 32'(reached), 32'd1);
    locked_i = 1'b0;
    stop_i   = 1'b1;
    tick_fb("loss");
    stop_i = 1'b0;
    check("loss.fault", 32'(fault_o), 32'd1);
    check("loss.no_block", 32'(block_o), 32'd0);
    stop_i = 1'b1;
    tick_fb("loss_clr");
    stop_i = 1'b0;
    check("loss_clr.fault", 32'(fault_o), 32'd0);

    // Lock timeout: FAULT 16 clocks after LOCK entry, start clears it
    start_i = 1'b1;
    tick_fb("tmo");
    start_i = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !fault_o; i++) begin
      tick_fb("tmo");
      n++;
    end
    check("tmo.latency", 32'(n), 32'(LOCK_WAIT));
    check("tmo.en_off", 32'(hilb_en_o), 32'd0);
    start_i = 1'b1;
    tick_fb("tmo_clr");
    start_i = 1'b0;
    check("tmo_clr.fault", 32'(fault_o), 32'd0);
    check("tmo_clr.en", 32'(hilb_en_o), 32'd1);

    // Asynchronous reset between edges while running
    locked_i = 1'b1;
    for (int i = 0; i < 7; i++) tick_fb("areset");
    check("areset.running", 32'(run_o), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    check("areset.en",    32'(hilb_en_o),  32'd0);
    check("areset.stb",   32'(hilb_stb_o), 32'd0);
    check("areset.busy",  32'(busy_o),     32'd0);
    check("areset.run",   32'(run_o),      32'd0);
    check("areset.block", 32'(block_o),    32'd0);
    check("areset.fault", 32'(fault_o),    32'd0);
    check("areset.count", 32'(count_o),    32'd0);
    #1 reset_i = 1'b0;
    model_reset();
    hstrobe_i = 1'b0;
    start_i = 1'b1;
    tick_fb("resume");
    start_i = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick_fb("resume");
      reached = (mode == M_RUN);
    end
    check("resume.count0", 32'(count_o), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      start_i   = ($urandom % 8) == 0;
      stop_i    = ($urandom % 12) == 0;
      locked_i  = ($urandom % 40) != 0;
      framed_i  = ($urandom % 4) != 0;
      hstrobe_i = ($urandom % 2) ? e_stb() : 1'($urandom % 2);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hilbert_sequencer.md
HILBERT_SEQUENCER -- requirements
Module: hilbert_sequencer

Interface
- REQ-001 Parameter RATIO, default 2: supersample ratio; one hilb_stb_o pulse every RATIO clocks; legal range >= 2.
- REQ-002 Parameter LOCK_WAIT, default 16: clocks allowed for locked_i to rise after enable.
- REQ-003 Parameter BLOCK, default 32: framed samples per block; power of two, >= 2.
- REQ-004 clock_i, input, 1: sole clock; all logic on its rising edge.
- REQ-005 reset_i, input, 1: asynchronous, active-high reset.
- REQ-006 start_i, input, 1: level request to begin or restart acquisition.
- REQ-007 stop_i, input, 1: request to stop at the next block boundary.
- REQ-008 locked_i, input, 1: lock status from the fake_hilbert bank.
- REQ-009 hstrobe_i, input, 1: output strobe from the fake_hilbert bank.
- REQ-010 framed_i, input, 1: frame-valid flag from the fake_hilbert bank, qualified by hstrobe_i.
- REQ-011 hilb_en_o, output, 1: enable_i of the fake_hilbert bank.
- REQ-012 hilb_stb_o, output, 1: strobe_i of the fake_hilbert bank.
- REQ-013 busy_o, output, 1: high in any state other than IDLE and FAULT.
- REQ-014 run_o, output, 1: high in RUN and DRAIN.
- REQ-015 block_o, output, 1: one-clock pulse at each completed block.
- REQ-016 fault_o, output, 1: sticky lock-timeout or lock-loss flag.
- REQ-017 count_o, output, log2(BLOCK): framed-sample index within the current block.

Function
- REQ-018 States: IDLE, LOCK, RUN, DRAIN, FAULT; all outputs are registered.
- REQ-019 Divider: counts 0..RATIO-1 and is cleared to 0 on entry to LOCK; hilb_stb_o = 1 when the divider equals RATIO-1 and the state is LOCK, RUN or DRAIN; otherwise 0.
- REQ-020 hilb_en_o = 1 in LOCK, RUN and DRAIN; 0 in IDLE and FAULT.
- REQ-021 IDLE -> LOCK when start_i = 1; stop_i is ignored in IDLE; start wins if both are high.
- REQ-022 LOCK: the timer is cleared on entry and increments each clock.
  - locked_i = 1 -> RUN.
  - Timer = LOCK_WAIT-1 with locked_i = 0 -> FAULT.
  - If locked_i rises on the timeout clock, RUN wins.
- REQ-023 RUN/DRAIN sample counting:
  - count_o increments on each clock with hstrobe_i & framed_i.
  - At BLOCK-1 it wraps to 0 and block_o pulses on the following clock.
- REQ-024 RUN -> DRAIN on stop_i = 1; if count_o = 0 and no qualified strobe is present in that clock, go directly to IDLE instead.
- REQ-025 DRAIN -> IDLE on the clock that count_o wraps; block_o still pulses for that final block.
- REQ-026 RUN or DRAIN with locked_i = 0 -> FAULT and fault_o = 1.
  - Lock loss has priority over stop_i and block completion.
  - block_o does not pulse for a block that completes in the same clock as lock loss.
- REQ-027 FAULT holds hilb_en_o = 0 and fault_o = 1.
  - start_i = 1 clears fault_o and goes to LOCK.
  - stop_i = 1 clears fault_o and goes to IDLE.
  - If both are high, start wins.
- REQ-028 count_o is cleared on entry to LOCK and holds its value in IDLE and FAULT.

Reset
- REQ-029 While reset_i = 1:
  - State is IDLE.
  - Divider, timer and count_o are 0.
  - hilb_en_o, hilb_stb_o, busy_o, run_o, block_o and fault_o are 0.
- REQ-030 Reset asserted mid-operation (including in RUN or DRAIN) forces REQ-029 values immediately, with no block_o pulse.

Structure
- REQ-031 The state encoding and the log2 width helper go in the shared correlator package; no other shared typedefs.
- REQ-032 The divider and lock timer are one sub-module, hilbert_strobe_gen (divider plus terminal-count flag); the FSM and sample counter stay in hilbert_sequencer.

Verification
- REQ-033 Nominal run, RATIO=2, BLOCK=4:
  - Stimulus: start; locked_i rises 3 clocks later; framed_i held high with hstrobe_i = hilb_stb_o delayed by 1.
  - Response: hilb_stb_o pulses every 2nd clock; block_o pulses every 8 clocks; count_o cycles 0,1,2,3.
- REQ-034 Lock timeout, LOCK_WAIT=16:
  - Stimulus: start with locked_i held 0.
  - Response: FAULT 16 clocks after LOCK entry; fault_o = 1; hilb_en_o = 0.
  - Then start_i clears fault_o and re-enters LOCK.
- REQ-035 Stop mid-block:
  - Stimulus: stop_i at count_o = 2, BLOCK=4.
  - Response: DRAIN; one further block_o pulse; IDLE; busy_o = 0 one clock after block_o.
- REQ-036 Lock loss during RUN:
  - Stimulus: locked_i drops in the same clock as stop_i and the final framed strobe.
  - Response: FAULT; no block_o pulse; fault_o = 1.
- REQ-037 Asynchronous reset:
  - Stimulus: reset_i pulsed mid-RUN between clock edges.
  - Response: all outputs 0 before the next edge; start then resumes at count_o = 0.
